// File: rtl/column_fifo_writer_pkg.sv
// Shared constants and state encoding for the readout FIFO write side.
// READ_WORDS is the burst length the read-side timing block must use.
package column_fifo_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLAG    = 2'd2
    } cfw_state_t;

    localparam int NUM_COLS_DEF      = 138;
    localparam int WORDS_PER_COL_DEF = 4;
    localparam int DATA_W_DEF        = 16;
    localparam int READ_WORDS        = NUM_COLS_DEF * WORDS_PER_COL_DEF;

endpackage

// File: rtl/column_fifo_writer.sv
// Captures per-column ADC words into the readout FIFO and pulses flag_138cols
// once NUM_COLS columns are buffered (coincident with the final write strobe).
module column_fifo_writer
    import column_fifo_writer_pkg::*;
#(
    parameter int NUM_COLS      = NUM_COLS_DEF,   // must be <= 255
    parameter int WORDS_PER_COL = WORDS_PER_COL_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              fifo_wr_clk,
    input  logic              rst,
    input  logic              col_start,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              flag_138cols,
    output logic [7:0]        col_count,
    output logic              overflow,
    output logic              frame_err
);

    localparam int             WCW        = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS_PER_COL - 1);
    localparam logic [7:0]     NUM_COLS_C = 8'(NUM_COLS);

    cfw_state_t        state, state_d;
    logic [WCW-1:0]    word_cnt, word_cnt_d;
    logic [7:0]        col_count_d;
    logic [DATA_W-1:0] din_d;
    logic              wr_en_d, flag_d, overflow_d, frame_err_d;

    always_ff @(posedge fifo_wr_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge fifo_wr_clk) begin
        if (rst) begin
            word_cnt     <= '0;
            col_count    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            flag_138cols <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            word_cnt     <= word_cnt_d;
            col_count    <= col_count_d;
            fifo_wr_en   <= wr_en_d;
            fifo_din     <= din_d;
            flag_138cols <= flag_d;
            overflow     <= overflow_d;
            frame_err    <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        word_cnt_d  = word_cnt;
        col_count_d = col_count;
        din_d       = fifo_din;
        wr_en_d     = 1'b0;
        flag_d      = 1'b0;
        overflow_d  = overflow;
        frame_err_d = frame_err;
        case (state)
            IDLE: begin
                if (col_start) begin
                    state_d    = CAPTURE;
                    word_cnt_d = '0;
                end
            end
            CAPTURE: begin
                if (col_start && word_cnt != '0) begin
                    frame_err_d = 1'b1;
                    word_cnt_d  = '0;
                end else if (adc_valid) begin
                    // A dropped word still advances word_cnt so framing holds.
                    din_d = adc_data;
                    if (fifo_full) overflow_d = 1'b1;
                    else           wr_en_d    = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_d  = '0;
                        col_count_d = col_count + 8'd1;
                        if (col_count_d == NUM_COLS_C) begin
                            state_d = FLAG;
                            flag_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        word_cnt_d = word_cnt + WCW'(1);
                    end
                end
            end
            FLAG: begin
                col_count_d = '0;
                word_cnt_d  = '0;
                state_d     = col_start ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
